// File: rtl/neuron_pkg.sv
// Shared types and helpers for the time-multiplexed neuron layer sequencer.
package neuron_pkg;

  typedef enum logic [2:0] {IDLE, CAPTURE, MUL, SAT, DONE} state_e;

  localparam int FRAC_BITS = 4;

  // Clamp a signed value into the unsigned range [0, 2**width-1].
  function automatic logic [31:0] sat_u(input logic signed [31:0] s, input int width);
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< width) - 32'sd1;
    if (s < 0) return '0;
    if (s > max_v) return unsigned'(max_v);
    return unsigned'(s);
  endfunction

endpackage

// File: rtl/neuron_mac_sat.sv
// Shared neuron datapath: registered two-term product sum, then
// combinational fixed-point rescale and unsigned saturation.
module neuron_mac_sat
  import neuron_pkg::*;
#(
  parameter int INT_WIDTH    = 4,
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic        [INT_WIDTH-1:0]    a1_i,
  input  logic        [INT_WIDTH-1:0]    a2_i,
  input  logic signed [WEIGHT_WIDTH-1:0] w1_i,
  input  logic signed [WEIGHT_WIDTH-1:0] w2_i,
  output logic        [INT_WIDTH-1:0]    s_o
);

  localparam int PW = INT_WIDTH + WEIGHT_WIDTH + 2;

  logic signed [INT_WIDTH:0] a1_s, a2_s;
  logic signed [PW-1:0]      prod1, prod2, p_q, p_d, shifted;

  // Activations are unsigned, so a zero sign bit keeps the multiply signed-correct.
  assign a1_s  = {1'b0, a1_i};
  assign a2_s  = {1'b0, a2_i};
  assign prod1 = PW'(a1_s) * PW'(w1_i);
  assign prod2 = PW'(a2_s) * PW'(w2_i);

  always_comb begin
    p_d = p_q;
    if (en_i) p_d = prod1 + prod2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

  assign shifted = p_q >>> FRAC_BITS;
  assign s_o     = INT_WIDTH'(sat_u(32'(shifted), INT_WIDTH));

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Evaluates a stack of 2-neuron layers one neuron at a time on a single
// shared MAC/saturate datapath, with a runtime-writable weight file.
module neuron_layer_sequencer
  import neuron_pkg::*;
#(
  parameter  int INT_WIDTH    = 4,
  parameter  int WEIGHT_WIDTH = 8,
  parameter  int LAYERS       = 2,
  localparam int ADDR_W       = $clog2(LAYERS*4)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic        [INT_WIDTH-1:0]    in1,
  input  logic        [INT_WIDTH-1:0]    in2,
  output logic                           busy,
  output logic                           done,
  output logic        [INT_WIDTH-1:0]    out,
  input  logic                           cfg_we,
  input  logic        [ADDR_W-1:0]       cfg_addr,
  input  logic signed [WEIGHT_WIDTH-1:0] cfg_data,
  output logic                           cfg_err
);

  localparam int NW = LAYERS * 4;
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  state_e                        state_q, state_d;
  logic [LW-1:0]                 layer_q, layer_d;
  logic                          neuron_q, neuron_d;
  logic [INT_WIDTH-1:0]          act_q [2];
  logic [INT_WIDTH-1:0]          act_d [2];
  logic [INT_WIDTH-1:0]          nxt_q [2];
  logic [INT_WIDTH-1:0]          nxt_d [2];
  logic [INT_WIDTH-1:0]          out_q, out_d, sat_s;
  logic                          cfg_err_q, cfg_err_d, wr_ok, last_layer;
  logic signed [WEIGHT_WIDTH-1:0] w_q [NW];
  logic [ADDR_W-1:0]             w_idx;

  // Writes are only safe while no evaluation is reading the weight file.
  assign wr_ok      = cfg_we && (state_q == IDLE) && (32'(cfg_addr) < NW);
  assign cfg_err_d  = cfg_we && !wr_ok;
  assign last_layer = (layer_q == LW'(LAYERS - 1));
  assign w_idx      = ADDR_W'(4 * 32'(layer_q) + 2 * 32'(neuron_q));

  for (genvar gi = 0; gi < NW; gi++) begin : g_weight
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                         w_q[gi] <= '0;
      else if (wr_ok && (cfg_addr == ADDR_W'(gi)))      w_q[gi] <= cfg_data;
    end
  end

  neuron_mac_sat #(
    .INT_WIDTH    (INT_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (state_q == MUL),
    .a1_i  (act_q[0]),
    .a2_i  (act_q[1]),
    .w1_i  (w_q[w_idx]),
    .w2_i  (w_q[w_idx + ADDR_W'(1)]),
    .s_o   (sat_s)
  );

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    act_d    = act_q;
    nxt_d    = nxt_q;
    out_d    = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          act_d[0] = in1;
          act_d[1] = in2;
          layer_d  = '0;
          neuron_d = 1'b0;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: state_d = MUL;
      MUL:     state_d = SAT;
      SAT: begin
        nxt_d[neuron_q] = sat_s;
        if (!neuron_q) begin
          neuron_d = 1'b1;
          state_d  = MUL;
        end else begin
          // Layer complete: its two results become the next layer's inputs.
          act_d[0] = nxt_q[0];
          act_d[1] = sat_s;
          neuron_d = 1'b0;
          if (last_layer) begin
            out_d   = nxt_q[0];
            state_d = DONE;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = MUL;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      layer_q   <= '0;
      neuron_q  <= 1'b0;
      act_q     <= '{default: '0};
      nxt_q     <= '{default: '0};
      out_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      neuron_q  <= neuron_d;
      act_q     <= act_d;
      nxt_q     <= nxt_d;
      out_q     <= out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign out     = out_q;
  assign cfg_err = cfg_err_q;

endmodule
